// File: rtl/fanout_pkg.sv
// Shared definitions for the fan-out broadcast controller and its polarity stages.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default data width / consumer count,
// broadcast-counter width and the pending-clear helper.
package fanout_pkg;

  // Controller FSM encoding. Kept as plain constants so older tools and
  // netlists see a stable one-bit state register.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BCAST = 1'b1;

  // Default geometry of the fan-out.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_OUT = 3;

  // Width of the completed-broadcast counter (and of its output port).
  localparam int CNT_W = 16;

  // Pending bits that survive a cycle: a consumer drops out of the pending
  // set on the edge where it both holds valid and sees ready.
  function automatic logic [15:0] pend_next(input logic [15:0] pending,
                                            input logic [15:0] ready);
    pend_next = pending & ~ready;
  endfunction

endpackage

// File: rtl/fanout_pol_stage.sv
// Per-consumer polarity stage: drives the held word either straight through or inverted.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; it carries data only, handshakes live in the controller.
//
// Ports:
//   din   in  WIDTH  held broadcast word
//   dout  out WIDTH  word as seen by this consumer (buf when INV=0, not when INV=1)
module fanout_pol_stage #(
  parameter int WIDTH = 8,
  parameter bit INV   = 1'b0
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // INV is an elaboration constant, so only one of the two paths survives.
  if (INV) begin : g_not
    assign dout = ~din;
  end else begin : g_buf
    assign dout = din;
  end

endmodule

// File: rtl/fanout_broadcast_ctrl.sv
// Broadcasts one producer word to N_OUT consumers, each with a fixed buf/not polarity.
// Latency: word captured at edge t is offered to consumers from edge t; 1 word/clk sustained.
// Backpressure: producer stalls until every enabled consumer has accepted the current word.
//
// Ports:
//   clk, rst     single rising-edge clock; asynchronous active-high reset
//   in_valid/in_ready/in_data    producer handshake and word
//   out_en       consumer enable mask, sampled only when a word is captured
//   out_valid/out_ready          per-consumer handshake
//   out_data     consumer i on bits [i*WIDTH +: WIDTH]
//   bcast_cnt    completed-broadcast count
//
// Build option: define FANOUT_BCAST_CNT_EN to implement bcast_cnt as a
// wrapping counter of completed broadcasts; otherwise it is tied to zero and
// no counter flops exist.
module fanout_broadcast_ctrl
  import fanout_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               N_OUT    = DEF_N_OUT,
  parameter logic [N_OUT-1:0] INV_MASK = 3'b001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [N_OUT-1:0]       out_en,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       bcast_cnt
);

  logic [0:0]       state_q;
  logic [WIDTH-1:0] hold_q;
  logic [N_OUT-1:0] pending_q;

  logic             in_idle;
  logic             complete;
  logic             capture;
  logic [N_OUT-1:0] pending_left;
  logic [15:0]      pend_wide;

  // Pending consumers that are not accepting this cycle. The helper works on
  // a 16-bit view, which covers the full legal N_OUT range.
  assign pend_wide    = pend_next(16'(pending_q), 16'(out_ready));
  assign pending_left = pend_wide[N_OUT-1:0];

  assign in_idle = (state_q == ST_IDLE);

  // Completion: we are broadcasting and every still-pending consumer is
  // taking the word on this edge. pending_q is never zero in BCAST.
  assign complete = (state_q == ST_BCAST) && (pending_left == '0);

  // Producer is released in IDLE or on the completion cycle, which lets a new
  // word ride the same edge as the last acceptance. Forced low during reset.
  assign in_ready = !rst && (in_idle || complete);
  assign capture  = in_valid && in_ready;

  assign out_valid = pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      pending_q <= '0;
    end else if (capture) begin
      // A word with an empty enable mask is swallowed: it updates hold but
      // leaves nothing pending, so the FSM stays (or falls back) in IDLE.
      hold_q    <= in_data;
      pending_q <= out_en;
      state_q   <= (out_en != '0) ? ST_BCAST : ST_IDLE;
    end else if (state_q == ST_BCAST) begin
      // Accepted consumers drop out and stay out until the next capture.
      pending_q <= pending_left;
      if (complete) begin
        state_q <= ST_IDLE;
      end
    end
  end

  // Per-consumer polarity selection.
  for (genvar i = 0; i < N_OUT; i++) begin : g_pol
    fanout_pol_stage #(
      .WIDTH (WIDTH),
      .INV   (INV_MASK[i])
    ) u_pol (
      .din  (hold_q),
      .dout (out_data[i*WIDTH +: WIDTH])
    );
  end

`ifdef FANOUT_BCAST_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts completion edges only; swallowed words never enter BCAST and so
  // are never counted. Natural wrap at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (complete) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bcast_cnt = cnt_q;
`else
  assign bcast_cnt = '0;
`endif

endmodule

// File: tb/tb_fanout_broadcast_ctrl.sv
module tb_fanout_broadcast_ctrl;

  localparam int W = 8;
  localparam int N = 3;
`ifdef FANOUT_BCAST_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic [N-1:0]   out_en = '0;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '0;
  logic [N*W-1:0] out_data;
  logic [15:0]    bcast_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fanout_broadcast_ctrl #(
    .WIDTH    (W),
    .N_OUT    (N),
    .INV_MASK (3'b001)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_en    (out_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .bcast_cnt (bcast_cnt)
  );

  typedef struct {
    logic         iv;
    logic [7:0]   id;
    logic [2:0]   en;
    logic [2:0]   rdy;
    logic         ir;
    logic [2:0]   ov;
    logic [23:0]  od;
    logic [15:0]  cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input logic [15:0] c);
    return CNT_ON ? c : 16'h0000;
  endfunction

  function automatic logic [23:0] od_of(input logic [7:0] w);
    return {w, w, ~w};
  endfunction

  initial begin
    // Each row: inputs driven at negedge, outputs sampled 1 time unit later.
    //             iv  data   en      rdy     ir   ov      out_data     cnt
    // Single word, all ready.
    vecs[0]  = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 3'b000, 24'h0000FF, 16'd0};
    vecs[1]  = '{1'b1, 8'hA5, 3'b111, 3'b111, 1'b1, 3'b000, 24'h0000FF, 16'd0};
    vecs[2]  = '{1'b0, 8'h00, 3'b111, 3'b111, 1'b1, 3'b111, 24'hA5A55A, 16'd0};
    vecs[3]  = '{1'b0, 8'h00, 3'b111, 3'b111, 1'b1, 3'b000, 24'hA5A55A, 16'd1};
    // Staggered: consumer 2 not ready for 4 cycles, next word on completion edge.
    vecs[4]  = '{1'b1, 8'h11, 3'b111, 3'b011, 1'b1, 3'b000, 24'hA5A55A, 16'd1};
    vecs[5]  = '{1'b1, 8'h22, 3'b111, 3'b011, 1'b0, 3'b111, 24'h1111EE, 16'd1};
    vecs[6]  = '{1'b1, 8'h22, 3'b111, 3'b011, 1'b0, 3'b100, 24'h1111EE, 16'd1};
    vecs[7]  = '{1'b1, 8'h22, 3'b111, 3'b011, 1'b0, 3'b100, 24'h1111EE, 16'd1};
    vecs[8]  = '{1'b1, 8'h22, 3'b111, 3'b011, 1'b0, 3'b100, 24'h1111EE, 16'd1};
    vecs[9]  = '{1'b1, 8'h22, 3'b111, 3'b111, 1'b1, 3'b100, 24'h1111EE, 16'd1};
    vecs[10] = '{1'b0, 8'h00, 3'b111, 3'b111, 1'b1, 3'b111, 24'h2222DD, 16'd2};
    // Masked enable, then an all-zero enable that is swallowed.
    vecs[11] = '{1'b1, 8'h3C, 3'b010, 3'b000, 1'b1, 3'b000, 24'h2222DD, 16'd3};
    vecs[12] = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 3'b010, 24'h3C3CC3, 16'd3};
    vecs[13] = '{1'b0, 8'h00, 3'b000, 3'b010, 1'b1, 3'b010, 24'h3C3CC3, 16'd3};
    vecs[14] = '{1'b1, 8'h77, 3'b000, 3'b111, 1'b1, 3'b000, 24'h3C3CC3, 16'd4};
    vecs[15] = '{1'b0, 8'h00, 3'b000, 3'b111, 1'b1, 3'b000, 24'h777788, 16'd4};
    // Completion together with capture of a swallowed word: back to IDLE.
    vecs[16] = '{1'b1, 8'h0F, 3'b101, 3'b000, 1'b1, 3'b000, 24'h777788, 16'd4};
    vecs[17] = '{1'b1, 8'hF0, 3'b000, 3'b101, 1'b1, 3'b101, 24'h0F0FF0, 16'd4};
    vecs[18] = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 3'b000, 24'hF0F00F, 16'd5};
    // out_en changes while a word is in flight are ignored.
    vecs[19] = '{1'b1, 8'h55, 3'b011, 3'b000, 1'b1, 3'b000, 24'hF0F00F, 16'd5};
    vecs[20] = '{1'b0, 8'h00, 3'b111, 3'b001, 1'b0, 3'b011, 24'h5555AA, 16'd5};
    vecs[21] = '{1'b0, 8'h00, 3'b000, 3'b010, 1'b1, 3'b010, 24'h5555AA, 16'd5};
    vecs[22] = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 3'b000, 24'h5555AA, 16'd6};

    // Reset state.
    @(negedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'h0000FF);
    check("reset bcast_cnt", 64'(bcast_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      in_valid  = vecs[v].iv;
      in_data   = vecs[v].id;
      out_en    = vecs[v].en;
      out_ready = vecs[v].rdy;
      #1;
      check($sformatf("vec%0d in_ready", v), 64'(in_ready), 64'(vecs[v].ir));
      check($sformatf("vec%0d out_valid", v), 64'(out_valid), 64'(vecs[v].ov));
      check($sformatf("vec%0d out_data", v), 64'(out_data), 64'(vecs[v].od));
      check($sformatf("vec%0d bcast_cnt", v), 64'(bcast_cnt), 64'(cnt_exp(vecs[v].cnt)));
    end

    // Back-to-back: 16 words at one per clock, all consumers ready.
    for (int k = 0; k < 18; k++) begin
      logic [7:0]  w;
      logic [15:0] c;
      @(negedge clk);
      in_valid  = (k < 16);
      in_data   = 8'(k);
      out_en    = 3'b111;
      out_ready = 3'b111;
      #1;
      w = (k == 0) ? 8'h55 : ((k > 16) ? 8'h0F : 8'(k - 1));
      c = 16'd6 + ((k == 0) ? 16'd0 : ((k > 16) ? 16'd16 : 16'(k - 1)));
      check($sformatf("b2b%0d in_ready", k), 64'(in_ready), 64'd1);
      check($sformatf("b2b%0d out_valid", k), 64'(out_valid),
            ((k >= 1) && (k <= 16)) ? 64'h7 : 64'h0);
      check($sformatf("b2b%0d out_data", k), 64'(out_data), 64'(od_of(w)));
      check($sformatf("b2b%0d bcast_cnt", k), 64'(bcast_cnt), 64'(cnt_exp(c)));
    end

    // Asynchronous reset while consumers 0 and 2 are pending.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'hC3;
    out_en    = 3'b101;
    out_ready = 3'b000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre-rst out_valid", 64'(out_valid), 64'h5);
    check("pre-rst in_ready", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid-rst out_valid", 64'(out_valid), 64'd0);
    check("mid-rst in_ready", 64'(in_ready), 64'd0);
    check("mid-rst out_data", 64'(out_data), 64'h0000FF);
    check("mid-rst bcast_cnt", 64'(bcast_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 64'(in_ready), 64'd1);
    check("post-rst out_valid", 64'(out_valid), 64'd0);
    check("post-rst out_data", 64'(out_data), 64'h0000FF);

`ifdef FANOUT_BCAST_CNT_EN
    // Counter wrap from all-ones on the next completion.
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    #1;
    check("wrap preload", 64'(bcast_cnt), 64'hFFFF);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h81;
    out_en    = 3'b111;
    out_ready = 3'b111;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("wrap out_valid", 64'(out_valid), 64'h7);
    @(negedge clk);
    #1;
    check("wrap bcast_cnt", 64'(bcast_cnt), 64'h0);
`else
    // Without the counter option the port stays at zero after further traffic.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h81;
    out_en    = 3'b111;
    out_ready = 3'b111;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("nocnt out_data", 64'(out_data), 64'h81817E);
    @(negedge clk);
    #1;
    check("nocnt bcast_cnt", 64'(bcast_cnt), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fanout_broadcast_ctrl.md
# fanout_broadcast_ctrl

Sequencing controller for the multi-output gate datapath. It accepts one data word from a single producer over a valid/ready handshake and broadcasts it to N_OUT consumers. Each consumer gets its copy either buffered or inverted, fixed per output at elaboration. The block tracks per-consumer acceptance and releases the producer only once every enabled consumer has taken the word, so back-pressure from any one consumer stalls the whole fan-out.

## Interface
- `WIDTH`, 8: data word width.
- `N_OUT`, 3: number of consumers (1..16).
- `INV_MASK`, 3'b001: bit i = 1 drives consumer i the inverted word (not path); 0 drives it the buffered word (buf path).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer word valid.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  WIDTH  producer word.
- `out_en`  in  N_OUT  consumer enable mask, sampled only at word capture.
- `out_valid`  out  N_OUT  per-consumer valid.
- `out_ready`  in  N_OUT  per-consumer ready.
- `out_data`  out  N_OUT*WIDTH  consumer i occupies bits [i*WIDTH +: WIDTH].
- `bcast_cnt`  out  16  completed-broadcast count (see Configuration).

## Operation
- Internal state: `hold` (WIDTH), `pending` (N_OUT), FSM {IDLE, BCAST}.
- Reset values: FSM=IDLE, hold=0, pending=0, out_valid=0, bcast_cnt=0. in_ready=0 while rst is high.
- `out_valid = pending`.
- `out_data[i] = INV_MASK[i] ? ~hold : hold`.
- Handshake fires when valid & ready on the same rising edge. Once valid is asserted, it must not drop until the handshake fires. Same rule applies to the producer and each consumer.
- IDLE: in_ready=1. On in_valid:
  - hold←in_data, pending←out_en.
  - Go to BCAST if out_en≠0.
  - If out_en==0, the word is consumed and discarded; stay in IDLE.
- BCAST:
  - Each consumer i with out_valid[i]&out_ready[i] clears pending[i].
  - Consumers complete independently, in any order.
- Completion: the cycle in which every remaining pending bit is being accepted.
  - in_ready=1 combinationally in that cycle.
  - If in_valid is also high, capture the new word in the same edge and stay in BCAST (or go to IDLE if the new out_en==0).
  - Otherwise go to IDLE.
- in_ready=0 in BCAST whenever any pending consumer is not ready.
- out_en changes outside capture cycles have no effect on the word in flight.
- Reset mid-broadcast: the in-flight word is lost, all out_valid drop immediately (async), and the FSM returns to IDLE.

## Timing
- Capture at edge t → out_valid asserted from edge t (visible in cycle t+1).
- Minimum per-word occupancy is one cycle. With all enabled consumers ready, sustained throughput is 1 word/clk.
- in_ready has a combinational path from out_ready; no combinational path from in_valid to out_valid.
- A slow consumer holding ready low for k cycles stalls in_ready for k cycles. Already-accepted consumers stay deasserted during the stall.

## Configuration
- `FANOUT_BCAST_CNT_EN` defined:
  - `bcast_cnt` increments by 1 on each completion edge.
  - Discarded (out_en==0) words do not count.
  - Wraps 16'hFFFF→16'h0000.
  - Resets to 0.
- Not defined: `bcast_cnt` is tied to 16'h0000 and no counter flops are generated. The port is always present.

## Structure
- Shared package `fanout_pkg`:
  - FSM state encoding (IDLE=1'b0, BCAST=1'b1).
  - Default WIDTH/N_OUT.
  - Counter width constant (16).
- Sub-module `fanout_pol_stage`: combinational per-output buf/not selector, parameterised by WIDTH and INV. Instantiated N_OUT times via generate. The controller's FSM and pending logic stay in the top.

## Test plan
- Reset then single word: in_data=8'hA5, out_en=3'b111, all ready → out_data = {8'hA5, 8'hA5, 8'h5A}, out_valid=3'b111 for 1 cycle, in_ready stays 1.
- Staggered acceptance: out_ready held low on consumer 2 for 4 cycles → in_ready=0 for those 4 cycles, pending goes 3'b111→3'b100, then completes; next word is captured on the completion edge.
- Back-to-back: 16 words 8'h00..8'h0F with all ready → one word per clock, each consumer sees all 16 in order, bcast_cnt=16 (with macro).
- Masked: out_en=3'b010, in_data=8'h3C → only out_valid[1] asserts. out_en=3'b000 → word accepted and dropped, out_valid stays 0, bcast_cnt unchanged.
- Async reset mid-BCAST with pending=3'b101 → out_valid=0 and in_ready=0 immediately; after release, in_ready=1 and hold=0.
- Counter wrap (macro on): preload via 65535 broadcasts or a force → next completion gives bcast_cnt=16'h0000. Macro off → bcast_cnt constant 0.
